// File: rtl/serial_divider_32bit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// A new divide is accepted in IDLE. It takes 32 CALC iterations and one FIX
// cycle, and the result is presented for a single DONE cycle. Divide-by-zero
// and signed overflow are resolved at accept time, so they skip the iterations.
module serial_divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] quo_reg;     // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_reg;     // divisor magnitude
  logic [WIDTH:0]   rem_reg;     // partial remainder, one guard bit
  logic [5:0]       cnt_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             ready_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] result_reg;

  // Operand conditioning at accept: magnitudes, signs and special cases
  logic             is_signed;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             div_zero;
  logic             sign_ovf;

  assign is_signed = ~i_op[0];
  assign dvd_neg   = is_signed & i_dividend[WIDTH-1];
  assign dvs_neg   = is_signed & i_divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? (WIDTH'(0) - i_dividend) : i_dividend;
  assign dvs_mag   = dvs_neg ? (WIDTH'(0) - i_divisor) : i_divisor;
  assign div_zero  = (i_divisor == '0);
  assign sign_ovf  = is_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (i_divisor == '1);

  // One iteration: shift in the next dividend bit, then trial subtract as A + ~B + 1
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;

  assign shifted   = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
  assign trial     = {1'b0, shifted} + {1'b0, ~{1'b0, dvs_reg}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign no_borrow = trial[WIDTH+1];

  // Sign fix-up of the final quotient and remainder
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign q_fix = q_neg_reg ? (WIDTH'(0) - quo_reg) : quo_reg;
  assign r_fix = r_neg_reg ? (WIDTH'(0) - rem_reg[WIDTH-1:0]) : rem_reg[WIDTH-1:0];

  // Control FSM and datapath registers. Flush returns to IDLE from any state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      rem_reg    <= '0;
      cnt_reg    <= '0;
      q_neg_reg  <= 1'b0;
      r_neg_reg  <= 1'b0;
      ready_reg  <= 1'b1;
      valid_reg  <= 1'b0;
      result_reg <= '0;
    end else if (i_flush) begin
      state_reg <= IDLE;
      ready_reg <= 1'b1;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_start) begin
            op_reg    <= i_op;
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            dvs_reg   <= dvs_mag;
            if (div_zero) begin
              // The final values are loaded directly and the FIX slot only
              // selects between them, so the result appears one cycle after accept
              quo_reg   <= '1;
              rem_reg   <= {1'b0, i_dividend};
              q_neg_reg <= 1'b0;
              r_neg_reg <= 1'b0;
              state_reg <= FIX;
            end else if (sign_ovf) begin
              quo_reg   <= {1'b1, {(WIDTH-1){1'b0}}};
              rem_reg   <= '0;
              q_neg_reg <= 1'b0;
              r_neg_reg <= 1'b0;
              state_reg <= FIX;
            end else begin
              quo_reg   <= dvd_mag;
              rem_reg   <= '0;
              q_neg_reg <= dvd_neg ^ dvs_neg;
              r_neg_reg <= dvd_neg;
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          quo_reg <= {quo_reg[WIDTH-2:0], no_borrow};
          rem_reg <= no_borrow ? trial[WIDTH:0] : shifted;
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == 6'(WIDTH-1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= op_reg[1] ? r_fix : q_fix;
          valid_reg  <= 1'b1;
          state_reg  <= DONE;
        end
        default: begin
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign o_ready  = ready_reg;
  assign o_valid  = valid_reg;
  assign o_result = result_reg;

endmodule

// File: tb/tb_serial_divider_32bit.sv
// Scoreboard bench for serial_divider_32bit: the driver pushes reference
// results at accept and the monitor pops and compares them on o_valid.
module tb_serial_divider_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        valid;
  logic [31:0] result;

  serial_divider_32bit #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_start(start),
    .i_op(op), .i_dividend(a), .i_divisor(b),
    .o_ready(ready), .o_valid(valid), .o_result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_res_q[$];
  int          exp_cyc_q[$];
  int          busy_from = -1;
  int          busy_to = -2;
  logic        prev_valid = 1'b0;
  logic [31:0] last_res = '0;

  // Reference behaviour in plain arithmetic; SV signed division truncates toward zero
  function automatic logic [31:0] ref_model(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    logic [31:0] q;
    logic [31:0] r;
    if (y == 0) begin
      q = 32'hFFFFFFFF; r = x;
    end else if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
      q = 32'h80000000; r = 0;
    end else if (!o[0]) begin
      q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
    end else begin
      q = x / y; r = x % y;
    end
    return o[1] ? r : q;
  endfunction

  function automatic int ref_latency(logic [1:0] o, logic [31:0] x, logic [31:0] y);
    if (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: handshake properties every cycle, scoreboard compare on o_valid
  always @(negedge clk) begin
    if (rst_n) begin
      if (cyc >= busy_from && cyc <= busy_to) chk("ready_low_busy", {31'd0, ready}, 32'd0);
      if (valid) begin
        chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        if (exp_res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: result %h with empty scoreboard (cycle %0d)", result, cyc);
        end else begin
          logic [31:0] e;
          int          ec;
          e  = exp_res_q.pop_front();
          ec = exp_cyc_q.pop_front();
          chk("result", result, e);
          chk("latency", cyc, ec);
          last_res = e;
          $display("txn: result=%h expected=%h cycle=%0d expected_cycle=%0d", result, e, cyc, ec);
        end
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Hold i_start with new operands until accepted; record the expectation
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int c0);
    bit acc;
    int lat;
    acc = 0;
    c0  = 0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (ready && !flush) begin
        acc = 1;
        c0  = cyc + 1;
        lat = ref_latency(o, x, y);
        exp_res_q.push_back(ref_model(o, x, y));
        exp_cyc_q.push_back(c0 + lat);
        busy_from = c0;
        busy_to   = c0 + lat;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready never rose for op=%0d %h/%h", o, x, y);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_res_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_res_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_res_q.size());
      exp_res_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  logic [1:0]  d_op[11] = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd0, 2'd2};
  logic [31:0] d_a[11]  = '{32'd100, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                            32'd7, 32'd7, 32'd5, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
  logic [31:0] d_b[11]  = '{32'd7, 32'd7, 32'd1, 32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE,
                            32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};

  initial begin
    int          c0;
    int          k;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    rst_n = 1'b1;

    // Directed cases, issued back to back with i_start held high throughout
    for (int i = 0; i < 11; i++) issue(d_op[i], d_a[i], d_b[i], c0);
    go_idle();
    drain();

    // Flush mid-CALC: no pulse, result held, then a normal divide
    issue(2'd1, 32'd1000, 32'd3, c0);
    k = 0;
    while (cyc < c0 + 10 && k < 50) begin
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    flush = 1'b1;
    busy_to = c0 + 10;
    void'(exp_res_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {31'd0, ready}, 32'd1);
    chk("flush_no_valid", {31'd0, valid}, 32'd0);
    chk("flush_hold_result", result, last_res);
    repeat (40) @(negedge clk);
    chk("flush_hold_result_late", result, last_res);
    issue(2'd1, 32'd9, 32'd3, c0);
    go_idle();
    drain();

    // Flush together with start in IDLE must not accept
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'd1; a = 32'd50; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_no_accept", {31'd0, ready}, 32'd1);
    repeat (40) @(negedge clk);
    chk("flush_start_result", result, last_res);

    // Asynchronous reset in the middle of CALC, away from any clock edge
    issue(2'd1, 32'hDEADBEEF, 32'd77, c0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_ready", {31'd0, ready}, 32'd1);
    chk("async_reset_valid", {31'd0, valid}, 32'd0);
    chk("async_reset_result", result, 32'd0);
    start = 1'b0;
    exp_res_q.delete();
    exp_cyc_q.delete();
    busy_to = -2;
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized divides with corner values mixed in
    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb, c0);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_divider_32bit.md
Name: serial_divider_32bit

Overview:
- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Complements the combinational add datapath: each iteration is one trial subtraction, done as A + ~B with carry-in 1.
- Sits beside the ALU in the execute stage. It uses a start/ready/valid handshake so the pipeline can stall on it.
- Accepts a flush so that wrong-path (mispredicted) divides are squashed.

Parameters:
- WIDTH, 32, operand and result width; also the iteration count. Only 32 is verified.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_flush  input  1  abort any operation in flight; return to IDLE.
- i_start  input  1  request a new divide; accepted only when o_ready=1.
- i_op  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_dividend  input  WIDTH  dividend; sampled on accept only.
- i_divisor  input  WIDTH  divisor; sampled on accept only.
- o_ready  output  1  high only in IDLE.
- o_valid  output  1  one-cycle pulse; o_result is valid while it is high.
- o_result  output  WIDTH  quotient or remainder, per the latched i_op.

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low. Clock port is i_clk, reset port is i_rst_n.
- Reset values: state IDLE, o_ready=1, o_valid=0, o_result=0, all internal registers 0.
- States: IDLE, CALC, FIX, DONE.
- Accept: i_start & o_ready & ~i_flush at edge E0 latches the operands, i_op and the sign info.
  - Signed ops (DIV, REM) convert both operands to magnitudes.
  - Record the quotient sign = sign(dividend) XOR sign(divisor).
  - Record the remainder sign = sign(dividend).
- Special cases, detected at accept; these skip CALC and FIX and go straight to DONE at E1:
  - Divisor = 0: quotient 0xFFFFFFFF; remainder = original dividend (both signed and unsigned).
  - DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF: quotient 0x80000000; remainder 0.
- CALC: iterations at E1..E32, tracked by a 6-bit counter.
  - Each iteration shifts the {partial remainder, dividend} pair left by 1.
  - Trial subtract on a WIDTH+1-bit remainder.
  - No borrow: keep the difference and set quotient bit 1. Borrow: restore and set quotient bit 0.
  - After the 32nd iteration (E32), go to FIX.
- FIX: at E33, apply two's-complement negation to the quotient and remainder where the recorded signs require it, select by i_op, latch into o_result, go to DONE.
- DONE: o_valid=1 for exactly one cycle; at the next edge return to IDLE.
- Latency: normal ops give o_valid high in the cycle after E33; special cases give o_valid high in the cycle after E1.
- Throughput: a new accept is possible the cycle after DONE.
- o_result holds its value until the next FIX or special-case latch; it is not cleared by DONE exiting.
- i_start while not in IDLE: ignored, no queueing.
- i_flush:
  - Any state goes to IDLE at the next edge; o_valid forced 0 that cycle and after; o_result unchanged.
  - i_flush together with i_start in IDLE: no accept.
  - i_flush in DONE: suppresses nothing already seen, since o_valid was high during that cycle; the state still returns to IDLE.
- Async reset mid-operation: immediately go to IDLE with reset values, independent of the clock.
- Inputs are not required to stay stable after accept.
- Unsigned ops treat bit 31 as magnitude; no negation.

Test Plan:
- Reset: drive i_rst_n=0 mid-CALC with no clock edge -> o_ready=1, o_valid=0, o_result=0 immediately.
- Unsigned: DIVU 100/7 accepted at E0 -> o_valid high after E33 with o_result=14. REMU 100/7 -> 2. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Signed: DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIV 7/-2 -> -3. REM 7/-2 -> 1.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF one cycle after accept; REM -5/0 -> 0xFFFFFFFB.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Flush: assert i_flush at E10 of a DIVU -> IDLE at E11, no o_valid pulse, o_result keeps its previous value. A following DIVU 9/3 then returns 3.
- Handshake: pulse i_start every cycle across two back-to-back divides -> the second accepts only in IDLE after DONE. Check o_valid is exactly one cycle and o_ready=0 from accept through DONE.
